// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: load opcode and funct3 codes, MEM->WB payload.
// Payload fields are sized for the widest configuration; narrower stages use the low bits.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam int XLEN_MAX           = 64;
    localparam int REG_ADDR_WIDTH_MAX = 8;
    localparam int RESULTSRC_WIDTH_MAX = 4;

    typedef struct packed {
        logic                           reg_write;
        logic [RESULTSRC_WIDTH_MAX-1:0] result_src;
        logic [REG_ADDR_WIDTH_MAX-1:0]  rd;
        logic [XLEN_MAX-1:0]            calc_result;
        logic [XLEN_MAX-1:0]            read_data;
        logic [XLEN_MAX-1:0]            pc_plus4;
        logic                           misalign;
    } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_stage_skid_if.sv
// MEM->WB stage bundle: MEM-side valid/ready + payload, WB-side valid/ready + head entry.
// master = surrounding pipeline (drives MEM side, consumes WB side), slave = the stage.
interface mem_wb_stage_skid_if #(
    parameter int XLEN            = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int RESULTSRC_WIDTH = 2
);
    localparam int OFF_WIDTH = $clog2(XLEN/8);

    logic                       flush_i;
    logic                       in_valid;
    logic                       in_ready;
    logic                       is_load_M;
    logic [2:0]                 funct3_M;
    logic [OFF_WIDTH-1:0]       byte_off_M;
    logic                       RegWrite_M;
    logic [RESULTSRC_WIDTH-1:0] ResultSrc_M;
    logic [REG_ADDR_WIDTH-1:0]  rd_M;
    logic [XLEN-1:0]            calc_result_M;
    logic [XLEN-1:0]            ReadData_M;
    logic [XLEN-1:0]            PCplus4_M;
    logic                       out_valid;
    logic                       out_ready;
    logic                       RegWrite_W;
    logic [RESULTSRC_WIDTH-1:0] ResultSrc_W;
    logic [REG_ADDR_WIDTH-1:0]  rd_W;
    logic [XLEN-1:0]            calc_result_W;
    logic [XLEN-1:0]            ReadData_W;
    logic [XLEN-1:0]            PCplus4_W;
    logic                       misalign_W;

    modport master (
        output flush_i, in_valid, is_load_M, funct3_M, byte_off_M, RegWrite_M,
               ResultSrc_M, rd_M, calc_result_M, ReadData_M, PCplus4_M, out_ready,
        input  in_ready, out_valid, RegWrite_W, ResultSrc_W, rd_W, calc_result_W,
               ReadData_W, PCplus4_W, misalign_W
    );

    modport slave (
        input  flush_i, in_valid, is_load_M, funct3_M, byte_off_M, RegWrite_M,
               ResultSrc_M, rd_M, calc_result_M, ReadData_M, PCplus4_M, out_ready,
        output in_ready, out_valid, RegWrite_W, ResultSrc_W, rd_W, calc_result_W,
               ReadData_W, PCplus4_W, misalign_W
    );

endinterface

// File: rtl/mem_wb_stage_skid_load_formatter.sv
// Aligns raw load data by byte offset and sign/zero-extends by funct3; flags misalignment.
// Purely combinational, no handshake.
module load_formatter
    import rv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int OFF_WIDTH = $clog2(XLEN/8)
) (
    input  logic                 is_load,
    input  logic [2:0]           funct3,
    input  logic [OFF_WIDTH-1:0] byte_off,
    input  logic [XLEN-1:0]      raw,
    output logic [XLEN-1:0]      data,
    output logic                 misalign
);

    logic [XLEN-1:0] sh;

    assign sh = raw >> {byte_off, 3'b000};

    always_comb begin
        data     = raw;
        misalign = 1'b0;
        if (is_load) begin
            case (funct3)
                F3_LB:  data = XLEN'($signed(sh[7:0]));
                F3_LBU: data = XLEN'(sh[7:0]);
                F3_LH: begin
                    data     = XLEN'($signed(sh[15:0]));
                    misalign = byte_off[0];
                end
                F3_LHU: begin
                    data     = XLEN'(sh[15:0]);
                    misalign = byte_off[0];
                end
                F3_LW: begin
                    data     = XLEN'($signed(sh[31:0]));
                    misalign = |byte_off[1:0];
                end
                // 64-bit-only codes fall back to raw data on an RV32 stage
                F3_LWU: if (XLEN == 64) begin
                    data     = XLEN'(sh[31:0]);
                    misalign = |byte_off[1:0];
                end
                F3_LD: if (XLEN == 64) begin
                    data     = sh;
                    misalign = |byte_off;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage_skid.sv
// MEM->WB pipeline register as a 2-entry skid buffer (main + skid), load data formatted before capture.
// Latency 1 cycle; in_ready is registered and drops only while the skid entry is occupied.
module mem_wb_stage_skid
    import rv_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int RESULTSRC_WIDTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    mem_wb_stage_skid_if.slave bus
);

    localparam int OFF_WIDTH = $clog2(XLEN/8);

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t          state_q, state_d;
    mem_wb_payload_t main_q, skid_q, new_entry;
    logic [XLEN-1:0] fmt_data;
    logic            fmt_misalign;
    logic            in_ready, out_valid, accept, pop;
    logic            load_main, load_skid, main_from_skid;

    load_formatter #(.XLEN(XLEN), .OFF_WIDTH(OFF_WIDTH)) u_fmt (
        .is_load  (bus.is_load_M),
        .funct3   (bus.funct3_M),
        .byte_off (bus.byte_off_M),
        .raw      (bus.ReadData_M),
        .data     (fmt_data),
        .misalign (fmt_misalign)
    );

    always_comb begin
        new_entry             = '0;
        new_entry.reg_write   = bus.RegWrite_M;
        new_entry.result_src  = RESULTSRC_WIDTH_MAX'(bus.ResultSrc_M);
        new_entry.rd          = REG_ADDR_WIDTH_MAX'(bus.rd_M);
        new_entry.calc_result = XLEN_MAX'(bus.calc_result_M);
        new_entry.read_data   = XLEN_MAX'(fmt_data);
        new_entry.pc_plus4    = XLEN_MAX'(bus.PCplus4_M);
        new_entry.misalign    = fmt_misalign;
    end

    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin
                state_d   = FULL;
                load_main = 1'b1;
            end
            FULL: begin
                if (accept && !pop) begin
                    state_d   = SKID;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            SKID: if (pop) begin
                state_d        = FULL;
                main_from_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        // flush beats any same-cycle accept; payload contents are left stale
        if (bus.flush_i) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)           main_q <= new_entry;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= new_entry;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.RegWrite_W    = main_q.reg_write & out_valid;
    assign bus.misalign_W    = main_q.misalign & out_valid;
    assign bus.ResultSrc_W   = main_q.result_src[RESULTSRC_WIDTH-1:0];
    assign bus.rd_W          = main_q.rd[REG_ADDR_WIDTH-1:0];
    assign bus.calc_result_W = main_q.calc_result[XLEN-1:0];
    assign bus.ReadData_W    = main_q.read_data[XLEN-1:0];
    assign bus.PCplus4_W     = main_q.pc_plus4[XLEN-1:0];

endmodule

// File: doc/mem_wb_stage_skid.md
Name: mem_wb_stage_skid

Overview:
- Parametrised MEM->WB pipeline stage for the RISC-V 5-stage core, built as a 2-entry skid buffer with valid/ready handshakes on both sides.
- Aligns and sign/zero-extends load data by byte offset and funct3 before capture, for XLEN 32 or 64.
- Flags misaligned loads and supports synchronous flush.
- Sits between the data-memory stage and the register-file write port / forwarding unit.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- REG_ADDR_WIDTH, 5, register address width.
- RESULTSRC_WIDTH, 2, result-mux select width.
- OFF_WIDTH, $clog2(XLEN/8), byte-offset width; derived, do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; kills all held entries.
- in_valid  in  1  MEM side has a valid instruction.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- is_load_M  in  1  instruction is a load (opcode 0000011).
- funct3_M  in  3  load size/sign.
- byte_off_M  in  OFF_WIDTH  low address bits of the load.
- RegWrite_M  in  1  register write enable.
- ResultSrc_M  in  RESULTSRC_WIDTH  result-mux select.
- rd_M  in  REG_ADDR_WIDTH  destination register.
- calc_result_M  in  XLEN  ALU result.
- ReadData_M  in  XLEN  raw memory word.
- PCplus4_M  in  XLEN  PC+4.
- out_valid  out  1  WB-side entry valid.
- out_ready  in  1  WB consumes the entry.
- RegWrite_W  out  1  registered RegWrite AND out_valid.
- ResultSrc_W  out  RESULTSRC_WIDTH  from the head entry.
- rd_W  out  REG_ADDR_WIDTH  from the head entry.
- calc_result_W  out  XLEN  from the head entry.
- ReadData_W  out  XLEN  formatted load data.
- PCplus4_W  out  XLEN  from the head entry.
- misalign_W  out  1  head entry is a misaligned load.

Behaviour:
- Reset: every output is 0 (out_valid=0, RegWrite_W=0, misalign_W=0); in_ready=1 on the first cycle after reset release.
- Storage: main entry (drives the outputs) and skid entry, each a full payload plus a valid bit.
- States and transitions:
  - EMPTY: accept -> FULL.
  - FULL: accept and no pop -> SKID; accept and pop -> FULL (main takes the new payload); pop only -> EMPTY.
  - SKID: in_ready=0; pop moves skid -> main -> FULL; no pop -> stay.
  - accept = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY, or when FULL with a pop.
- Order is strictly FIFO; the skid entry is never bypassed.
- in_valid while in_ready=0 is ignored. MEM must hold its payload until accepted.
- Flush: on a flush_i cycle both valids clear and any same-cycle accept is discarded (flush wins). Next cycle out_valid=0, in_ready=1. Payload registers need not clear.
- RegWrite_W is gated by out_valid, so a bubble never writes the register file.
- Load formatting is combinational on the M inputs and applied before capture:
  - sh = ReadData_M >> (8*byte_off_M).
  - funct3 000 LB: sign-extend sh[7:0]. 001 LH: sign-extend sh[15:0]. 010 LW: sign-extend sh[31:0] (identity at XLEN=32).
  - 011 LD: sh, XLEN=64 only. 100 LBU, 101 LHU: zero-extend. 110 LWU: zero-extend sh[31:0], XLEN=64 only.
  - Any other funct3, or a 64-bit-only code at XLEN=32: raw ReadData_M, misalign=0.
  - Non-load: ReadData_M passes unchanged, misalign=0.
- Misalign: LH/LHU with byte_off[0]=1; LW/LWU with byte_off[1:0]!=0; LD with byte_off!=0. Data is still formatted from sh; the flag travels with the entry.
- Reset mid-operation: asynchronous clear of both valids and all outputs, with no dependency on clk.

Decomposition:
- Shared package rv_pkg: OPC_LOAD=7'b0000011; F3_LB/LH/LW/LD/LBU/LHU/LWU constants; typedef mem_wb_payload_t holding RegWrite, ResultSrc, rd, calc_result, ReadData, PCplus4 and misalign.
- Sub-module load_formatter: purely combinational, taking XLEN, funct3, byte_off, raw data and is_load; producing formatted data and misalign.
- The skid control and both entries stay in the top module.

Test Plan:
- XLEN=32, out_ready=1, LB, ReadData_M=0x0000_8000, byte_off=1 -> next cycle out_valid=1, ReadData_W=0xFFFF_FF80, misalign_W=0.
- XLEN=32, LHU, ReadData_M=0xBEEF_1234, byte_off=2 -> ReadData_W=0x0000_BEEF. Same input with byte_off=1 -> misalign_W=1.
- Backpressure: out_ready=0, send A, B, C back-to-back -> A held in main, B in skid, in_ready=0, C not accepted. Raise out_ready -> outputs A then B in order, in_ready=1 again.
- Flush in SKID with in_valid=1 -> next cycle out_valid=0, RegWrite_W=0, in_ready=1, and the same-cycle input never appears.
- XLEN=64, LWU, ReadData_M=0x1122_3344_8000_0000, byte_off=0 -> ReadData_W=0x0000_0000_8000_0000. LD with byte_off=4 -> misalign_W=1.
- Assert rst_n low while FULL with RegWrite=1 -> outputs 0 immediately (asynchronous). After release, in_ready=1 and out_valid=0.
